// File: rtl/uart_rx_deser.sv
// Oversampling UART receive deserializer: recovers 8-bit frames (optional parity)
// from a synchronized serial line and reports each byte plus per-frame error pulses.
module uart_rx_deser #(
  parameter int OVS = 16
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       RX,
  input  logic       tick16,
  input  logic       rx_en,
  input  logic       par_en,
  input  logic       par_odd,
  input  logic       fifo_full,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       err_par,
  output logic       err_frame,
  output logic       err_ovr,
  output logic       err_brk,
  output logic       busy,
  output logic [2:0] state_dbg
);

  localparam int CW = $clog2(OVS);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVS - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVS / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_PAR     = 3'd3,
    S_STOP    = 3'd4,
    S_WAIT_HI = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q, rx_meta_d;
  logic          rxs_q, rxs_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_next;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_en_q, par_en_d;
  logic          par_odd_q, par_odd_d;
  logic          par_bit_q, par_bit_d;
  logic [7:0]    dout_q, dout_d;
  logic          valid_q, valid_d;
  logic          err_par_q, err_par_d;
  logic          err_frame_q, err_frame_d;
  logic          err_ovr_q, err_ovr_d;
  logic          err_brk_q, err_brk_d;
  logic          is_brk;

  assign cnt_next = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  // Break: all-zero data, zero stop bit and (when enabled) zero parity bit.
  assign is_brk = (shift_q == 8'h00) && !rxs_q && (!par_en_q || !par_bit_q);

  always_comb begin
    rx_meta_d   = RX;
    rxs_d       = rx_meta_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    par_en_d    = par_en_q;
    par_odd_d   = par_odd_q;
    par_bit_d   = par_bit_q;
    dout_d      = dout_q;
    valid_d     = 1'b0;
    err_par_d   = 1'b0;
    err_frame_d = 1'b0;
    err_ovr_d   = 1'b0;
    err_brk_d   = 1'b0;

    if (!rx_en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!rxs_q) begin
            state_d = S_START;
            cnt_d   = '0;
          end
        end
        S_START: begin
          if (tick16) begin
            if (cnt_q == CNT_HALF) begin
              cnt_d = '0;
              if (!rxs_q) begin
                state_d   = S_DATA;
                bit_idx_d = 3'd0;
                par_en_d  = par_en;
                par_odd_d = par_odd;
              end else begin
                state_d = S_IDLE;
              end
            end else begin
              cnt_d = cnt_next;
            end
          end
        end
        S_DATA: begin
          if (tick16) begin
            cnt_d = cnt_next;
            if (cnt_q == CNT_LAST) begin
              shift_d   = {rxs_q, shift_q[7:1]};
              bit_idx_d = bit_idx_q + 3'd1;
              if (bit_idx_q == 3'd7) begin
                state_d = par_en_q ? S_PAR : S_STOP;
              end
            end
          end
        end
        S_PAR: begin
          if (tick16) begin
            cnt_d = cnt_next;
            if (cnt_q == CNT_LAST) begin
              par_bit_d = rxs_q;
              state_d   = S_STOP;
            end
          end
        end
        S_STOP: begin
          if (tick16) begin
            cnt_d = cnt_next;
            if (cnt_q == CNT_LAST) begin
              state_d     = rxs_q ? S_IDLE : S_WAIT_HI;
              dout_d      = shift_q;
              err_frame_d = !rxs_q;
              err_brk_d   = is_brk;
              err_par_d   = par_en_q && ((^shift_q ^ par_bit_q) != par_odd_q);
              // A break is a line condition, not a byte: never written downstream.
              valid_d     = !fifo_full && !is_brk;
              err_ovr_d   = fifo_full && !is_brk;
            end
          end
        end
        S_WAIT_HI: begin
          if (rxs_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      par_en_q    <= 1'b0;
      par_odd_q   <= 1'b0;
      par_bit_q   <= 1'b0;
      dout_q      <= 8'h00;
      valid_q     <= 1'b0;
      err_par_q   <= 1'b0;
      err_frame_q <= 1'b0;
      err_ovr_q   <= 1'b0;
      err_brk_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rxs_q       <= rxs_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      par_en_q    <= par_en_d;
      par_odd_q   <= par_odd_d;
      par_bit_q   <= par_bit_d;
      dout_q      <= dout_d;
      valid_q     <= valid_d;
      err_par_q   <= err_par_d;
      err_frame_q <= err_frame_d;
      err_ovr_q   <= err_ovr_d;
      err_brk_q   <= err_brk_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign err_par    = err_par_q;
  assign err_frame  = err_frame_q;
  assign err_ovr    = err_ovr_q;
  assign err_brk    = err_brk_q;
  assign busy       = (state_q != S_IDLE);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser: OVS=16, tick16 every 8 Clk, so one bit = 128 Clk.
module tb_uart_rx_deser;

  localparam int BIT = 128;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       RX = 1'b1;
  logic       tick16 = 1'b0;
  logic       rx_en = 1'b1;
  logic       par_en = 1'b0;
  logic       par_odd = 1'b0;
  logic       fifo_full = 1'b0;
  logic [7:0] dout;
  logic       dout_valid, err_par, err_frame, err_ovr, err_brk, busy;
  logic [2:0] state_dbg;

  int n_cmp = 0;
  int n_fail = 0;

  // Cumulative event counters maintained by the monitor.
  int n_valid = 0, n_par = 0, n_frm = 0, n_ovr = 0, n_brk = 0;
  int n_par_v = 0, n_frm_v = 0, busy_ticks = 0;
  logic [7:0] last_dout = 8'h00;
  logic       busy_prev = 1'b0;
  logic [2:0] tick_div = 3'd0;

  // Snapshots taken by the main sequence.
  int s_valid, s_par, s_frm, s_ovr, s_brk, s_par_v, s_frm_v, s_ticks;

  uart_rx_deser #(.OVS(16)) dut (
    .Clk(Clk), .Rst(Rst), .RX(RX), .tick16(tick16), .rx_en(rx_en),
    .par_en(par_en), .par_odd(par_odd), .fifo_full(fifo_full),
    .dout(dout), .dout_valid(dout_valid), .err_par(err_par),
    .err_frame(err_frame), .err_ovr(err_ovr), .err_brk(err_brk),
    .busy(busy), .state_dbg(state_dbg)
  );

  always #5 Clk = ~Clk;

  // Monitor and tick generator. A tick visible here was sampled at the previous
  // rising edge by the state that busy_prev describes.
  initial begin
    forever begin
      @(negedge Clk);
      if (dout_valid) begin
        n_valid++;
        last_dout = dout;
        if (err_par) n_par_v++;
        if (err_frame) n_frm_v++;
      end
      if (err_par) n_par++;
      if (err_frame) n_frm++;
      if (err_ovr) n_ovr++;
      if (err_brk) n_brk++;
      if (tick16 && busy_prev) busy_ticks++;
      busy_prev = busy;
      tick16 = (tick_div == 3'd7);
      tick_div = tick_div + 3'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_valid = n_valid; s_par = n_par; s_frm = n_frm; s_ovr = n_ovr;
    s_brk = n_brk; s_par_v = n_par_v; s_frm_v = n_frm_v; s_ticks = busy_ticks;
  endtask

  task automatic line(input logic v, input int nbits);
    RX = v;
    repeat (nbits * BIT) @(negedge Clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pb, input logic sb);
    line(1'b0, 1);
    for (int i = 0; i < 8; i++) line(d[i], 1);
    if (pe) line(pb, 1);
    line(sb, 1);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge Clk);
    check("rst_dout", dout, 8'h00);
    check("rst_valid", dout_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", state_dbg, 3'd0);
    check("rst_errs", {err_par, err_frame, err_ovr, err_brk}, 4'b0000);
    Rst = 1'b0;
    repeat (20) @(negedge Clk);

    // 8N1 0xA5: one clean strobe; START 8 + DATA 128 + STOP 16 ticks busy
    snap();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    line(1'b1, 1);
    check("a5_valid_cnt", n_valid - s_valid, 1);
    check("a5_dout", last_dout, 8'hA5);
    check("a5_errs", (n_par - s_par) + (n_frm - s_frm) + (n_ovr - s_ovr) + (n_brk - s_brk), 0);
    check("a5_busy_ticks", busy_ticks - s_ticks, 152);

    // 8O1 0x00 with parity bit 0: bad parity, reported with the strobe
    par_en = 1'b1; par_odd = 1'b1;
    snap();
    send_frame(8'h00, 1'b1, 1'b0, 1'b1);
    line(1'b1, 1);
    check("o1_valid_cnt", n_valid - s_valid, 1);
    check("o1_dout", last_dout, 8'h00);
    check("o1_par_with_valid", n_par_v - s_par_v, 1);
    check("o1_no_brk", n_brk - s_brk, 0);

    // 8E1 0x03 parity 0; parity settings changed mid-frame must be ignored
    par_en = 1'b1; par_odd = 1'b0;
    snap();
    line(1'b0, 1);
    line(1'b1, 1); line(1'b1, 1);
    par_en = 1'b0; par_odd = 1'b1;
    for (int i = 2; i < 8; i++) line(1'b0, 1);
    line(1'b0, 1);
    line(1'b1, 1);
    line(1'b1, 1);
    check("e1_valid_cnt", n_valid - s_valid, 1);
    check("e1_dout", last_dout, 8'h03);
    check("e1_no_par_err", n_par - s_par, 0);
    check("e1_no_frm_err", n_frm - s_frm, 0);

    // 8N1 0x3C with stop bit 0, line held low 2 more bit times
    snap();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    line(1'b0, 2);
    check("fe_busy_low", busy, 1'b1);
    check("fe_frm_with_valid", n_frm_v - s_frm_v, 1);
    check("fe_dout", last_dout, 8'h3C);
    check("fe_no_brk", n_brk - s_brk, 0);
    RX = 1'b1;
    repeat (6) @(negedge Clk);
    check("fe_busy_released", busy, 1'b0);
    line(1'b1, 1);

    // Break: line low 12 bit times
    snap();
    line(1'b0, 12);
    check("brk_busy_low", busy, 1'b1);
    check("brk_cnt", n_brk - s_brk, 1);
    check("brk_frm_cnt", n_frm - s_frm, 1);
    check("brk_no_valid", n_valid - s_valid, 0);
    RX = 1'b1;
    repeat (6) @(negedge Clk);
    check("brk_idle", state_dbg, 3'd0);
    line(1'b1, 1);

    // 0x55 with FIFO full: overrun, no strobe, dout still updated
    fifo_full = 1'b1;
    snap();
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    line(1'b1, 1);
    fifo_full = 1'b0;
    check("ovr_cnt", n_ovr - s_ovr, 1);
    check("ovr_no_valid", n_valid - s_valid, 0);
    check("ovr_dout", dout, 8'h55);

    // 3-tick glitch on idle line: START consumes OVS/2 ticks then gives up
    snap();
    RX = 1'b0;
    repeat (24) @(negedge Clk);
    line(1'b1, 2);
    check("gl_no_pulses", (n_valid - s_valid) + (n_frm - s_frm) + (n_ovr - s_ovr) + (n_brk - s_brk), 0);
    check("gl_busy_ticks", busy_ticks - s_ticks, 8);
    check("gl_busy_off", busy, 1'b0);

    // rx_en dropped mid-frame: abort without pulses
    snap();
    line(1'b0, 1);
    line(1'b1, 2);
    RX = 1'b1;
    repeat (BIT / 2) @(negedge Clk);
    rx_en = 1'b0;
    repeat (2) @(negedge Clk);
    check("en_abort_busy", busy, 1'b0);
    line(1'b1, 7);
    rx_en = 1'b1;
    line(1'b1, 1);
    check("en_no_pulses", (n_valid - s_valid) + (n_frm - s_frm) + (n_ovr - s_ovr) + (n_brk - s_brk), 0);

    // Rst during data bit 4 of 0xF0; line stays high afterwards
    snap();
    line(1'b0, 1);
    for (int i = 0; i < 4; i++) line(1'b0, 1);
    RX = 1'b1;
    repeat (BIT / 2) @(negedge Clk);
    Rst = 1'b1;
    #1;
    check("mrst_dout", dout, 8'h00);
    check("mrst_busy", busy, 1'b0);
    check("mrst_state", state_dbg, 3'd0);
    check("mrst_pulses", {dout_valid, err_par, err_frame, err_ovr, err_brk}, 5'b00000);
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    line(1'b1, 5);
    check("mrst_no_pulses", (n_valid - s_valid) + (n_frm - s_frm) + (n_ovr - s_ovr), 0);

    // Clean frame 0x81 after the reset
    snap();
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    line(1'b1, 1);
    check("post_valid_cnt", n_valid - s_valid, 1);
    check("post_dout", last_dout, 8'h81);
    check("post_errs", (n_par - s_par) + (n_frm - s_frm) + (n_ovr - s_ovr) + (n_brk - s_brk), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
